// File: rtl/cordic_fu_sequencer.sv
// Hyperbolic CORDIC iteration sequencer: time-multiplexes one shared add/shift FU
// over the x and y updates of each micro-rotation and tracks the z residue locally.
module cordic_fu_sequencer #(
    parameter int DWIDTH   = 16,
    parameter int MAXSHIFT = 16
) (
    input  logic                          iClk,
    input  logic                          iRstN,
    input  logic                          iValid,
    output logic                          oReady,
    input  logic [DWIDTH-1:0]             iX,
    input  logic [DWIDTH-1:0]             iY,
    input  logic [DWIDTH-1:0]             iZ,
    output logic                          oValid,
    input  logic                          iReady,
    output logic [DWIDTH-1:0]             oX,
    output logic [DWIDTH-1:0]             oY,
    output logic [DWIDTH-1:0]             oZ,
    output logic [DWIDTH-1:0]             oFuData1,
    output logic [DWIDTH-1:0]             oFuData2,
    output logic                          oFuSign,
    output logic                          oFuBypass,
    output logic [$clog2(MAXSHIFT+1)-1:0] oFuShift,
    input  logic [DWIDTH-1:0]             iFuResult,
    input  logic [DWIDTH-1:0]             iAtanh
);
    localparam int SW = $clog2(MAXSHIFT + 1);

    // Repeat indices follow i(n+1) = 3*i(n) + 1 starting at 4.
    function automatic int count_rep();
        int n;
        int v;
        n = 0;
        v = 4;
        for (int k = 0; k < 8; k++) begin
            if (v <= MAXSHIFT) n++;
            v = 3 * v + 1;
        end
        return n;
    endfunction

    function automatic logic is_rep(input logic [SW-1:0] i);
        logic r;
        int   v;
        r = 1'b0;
        v = 4;
        for (int k = 0; k < 8; k++) begin
            if (v <= MAXSHIFT && int'(i) == v) r = 1'b1;
            v = 3 * v + 1;
        end
        return r;
    endfunction

    localparam int NSTEP = MAXSHIFT + count_rep();
    localparam int STW   = $clog2(NSTEP + 1);

    typedef enum logic [1:0] {IDLE, XPH, YPH, DONE} state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d, xtmp_q, xtmp_d;
    logic [STW-1:0]    step_q, step_d;
    logic [SW-1:0]     shift_q, shift_d;
    logic              rep_q, rep_d;
    logic              neg;

    // z only changes on the YPH edge, so its sign is steady for the whole step.
    assign neg = z_q[DWIDTH-1];

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iValid) state_d = XPH;
            XPH:     state_d = YPH;
            YPH:     state_d = (step_q == STW'(NSTEP)) ? DONE : XPH;
            DONE:    if (iReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oReady    = (state_q == IDLE);
        oValid    = (state_q == DONE);
        oFuBypass = 1'b1;
        oFuSign   = 1'b0;
        oFuShift  = '0;
        oFuData1  = x_q;
        oFuData2  = y_q;
        if (state_q == XPH || state_q == YPH) begin
            oFuBypass = 1'b0;
            oFuSign   = neg;
            oFuShift  = shift_q;
            if (state_q == YPH) begin
                oFuData1 = y_q;
                oFuData2 = x_q;
            end
        end
    end

    assign oX = x_q;
    assign oY = y_q;
    assign oZ = z_q;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xtmp_d  = xtmp_q;
        step_d  = step_q;
        shift_d = shift_q;
        rep_d   = rep_q;
        case (state_q)
            IDLE: begin
                if (iValid) begin
                    x_d     = iX;
                    y_d     = iY;
                    z_d     = iZ;
                    step_d  = STW'(1);
                    shift_d = SW'(1);
                    rep_d   = 1'b0;
                end
            end
            XPH: xtmp_d = iFuResult;
            YPH: begin
                y_d    = iFuResult;
                x_d    = xtmp_q;
                z_d    = neg ? z_q + iAtanh : z_q - iAtanh;
                step_d = step_q + STW'(1);
                // A repeat index holds i for exactly one extra step.
                if (is_rep(shift_q) && !rep_q) begin
                    rep_d = 1'b1;
                end else begin
                    rep_d   = 1'b0;
                    shift_d = shift_q + SW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xtmp_q  <= '0;
            step_q  <= '0;
            shift_q <= '0;
            rep_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xtmp_q  <= xtmp_d;
            step_q  <= step_d;
            shift_q <= shift_d;
            rep_q   <= rep_d;
        end
    end
endmodule

// File: tb/tb_cordic_fu_sequencer.sv
// Bench for cordic_fu_sequencer: FU and atanh table models, a per-job golden
// trajectory model, and one compare process that checks every cycle.
module tb_cordic_fu_sequencer;
    localparam int DW    = 16;
    localparam int MS    = 16;
    localparam int NSTEP = 18;

    logic          iClk = 1'b0, iRstN = 1'b0, iValid = 1'b0, iReady = 1'b1;
    logic [DW-1:0] iX = '0, iY = '0, iZ = '0;
    logic          oReady, oValid, oFuSign, oFuBypass;
    logic [DW-1:0] oX, oY, oZ, oFuData1, oFuData2, iFuResult, iAtanh;
    logic [4:0]    oFuShift;

    cordic_fu_sequencer #(.DWIDTH(DW), .MAXSHIFT(MS)) dut (
        .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
        .iX(iX), .iY(iY), .iZ(iZ), .oValid(oValid), .iReady(iReady),
        .oX(oX), .oY(oY), .oZ(oZ), .oFuData1(oFuData1), .oFuData2(oFuData2),
        .oFuSign(oFuSign), .oFuBypass(oFuBypass), .oFuShift(oFuShift),
        .iFuResult(iFuResult), .iAtanh(iAtanh)
    );

    always #5 iClk = ~iClk;

    function automatic logic [DW-1:0] atanh_f(input int i);
        case (i)
            0: return 16'd0;     1: return 16'd2250; 2: return 16'd1046;
            3: return 16'd515;   4: return 16'd256;  5: return 16'd128;
            6: return 16'd64;    7: return 16'd32;   8: return 16'd16;
            9: return 16'd8;     10: return 16'd4;   11: return 16'd2;
            default: return 16'd1;
        endcase
    endfunction

    logic signed [DW-1:0] fu_sh;
    assign fu_sh     = $signed(oFuData2) >>> oFuShift;
    assign iFuResult = oFuBypass ? oFuData1 :
                       (oFuSign ? oFuData1 - fu_sh : oFuData1 + fu_sh);
    assign iAtanh    = atanh_f(int'(oFuShift));

    typedef enum {M_IDLE, M_BUSY, M_DONE} mst_t;
    mst_t          m_st = M_IDLE;
    int            m_cnt = 0;
    int            job_id = -1;
    logic          m_clean = 1'b1;
    logic [DW-1:0] lx = '0, ly = '0;
    logic [DW-1:0] sx [NSTEP+1];
    logic [DW-1:0] sy [NSTEP+1];
    logic [DW-1:0] sz [NSTEP+1];
    int            sh [NSTEP];
    int            lit_sched [NSTEP] = '{1,2,3,4,4,5,6,7,8,9,10,11,12,13,13,14,15,16};
    int            n_pass = 0, n_tot = 0;

    // Register contents before each step, plus the final result in slot NSTEP.
    task automatic build(input logic [DW-1:0] x0, input logic [DW-1:0] y0, input logic [DW-1:0] z0);
        int k;
        logic signed [DW-1:0] cx, cy, cz, dx, dy;
        k = 0;
        for (int i = 1; i <= MS; i++) begin
            sh[k] = i; k++;
            if (i == 4 || i == 13) begin sh[k] = i; k++; end
        end
        cx = x0; cy = y0; cz = z0;
        for (int s = 0; s < NSTEP; s++) begin
            sx[s] = cx; sy[s] = cy; sz[s] = cz;
            dx = cy >>> sh[s];
            dy = cx >>> sh[s];
            if (cz >= 0) begin
                cx = cx + dx; cy = cy + dy; cz = cz - atanh_f(sh[s]);
            end else begin
                cx = cx - dx; cy = cy - dy; cz = cz + atanh_f(sh[s]);
            end
        end
        sx[NSTEP] = cx; sy[NSTEP] = cy; sz[NSTEP] = cz;
    endtask

    always begin
        @(posedge iClk or negedge iRstN);
        if (!iRstN) begin
            m_st = M_IDLE; lx = '0; ly = '0; m_clean = 1'b1;
        end else begin
            case (m_st)
                M_IDLE: if (iValid) begin
                    build(iX, iY, iZ);
                    m_st = M_BUSY; m_cnt = 0; job_id++; m_clean = 1'b0;
                end
                M_BUSY: begin
                    m_cnt++;
                    if (m_cnt == 2 * NSTEP) m_st = M_DONE;
                end
                M_DONE: if (iReady) begin
                    m_st = M_IDLE; lx = sx[NSTEP]; ly = sy[NSTEP];
                end
                default: m_st = M_IDLE;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    endtask

    always begin
        int k;
        @(negedge iClk or negedge iRstN);
        #1;
        if (m_st == M_BUSY) begin
            k = m_cnt / 2;
            chk("ready", 32'(oReady), 32'd0);
            chk("valid", 32'(oValid), 32'd0);
            chk("bypass", 32'(oFuBypass), 32'd0);
            chk("shift", 32'(oFuShift), 32'(sh[k]));
            chk("sign", 32'(oFuSign), 32'(sz[k][DW-1]));
            if (m_cnt % 2 == 0) begin
                chk("xph_d1", 32'(oFuData1), 32'(sx[k]));
                chk("xph_d2", 32'(oFuData2), 32'(sy[k]));
            end else begin
                chk("yph_d1", 32'(oFuData1), 32'(sy[k]));
                chk("yph_d2", 32'(oFuData2), 32'(sx[k]));
            end
            if (job_id == 0) begin
                chk("lit_sched", 32'(oFuShift), 32'(lit_sched[k]));
                if (m_cnt == 0) begin
                    chk("lit_a_x1", 32'(oFuData1), 32'h1000);
                    chk("lit_a_x2", 32'(oFuData2), 32'h0000);
                    chk("lit_a_s1", 32'(oFuSign), 32'd0);
                end
                if (m_cnt == 1) begin
                    chk("lit_a_y1", 32'(oFuData1), 32'h0000);
                    chk("lit_a_y2", 32'(oFuData2), 32'h1000);
                end
                if (m_cnt == 2) begin
                    chk("lit_a_x1s2", 32'(oFuData1), 32'h1000);
                    chk("lit_a_x2s2", 32'(oFuData2), 32'h0800);
                    chk("lit_a_s2", 32'(oFuSign), 32'd1);
                end
            end
            if (job_id == 1) begin
                if (m_cnt == 0) chk("lit_b_s1", 32'(oFuSign), 32'd1);
                if (m_cnt == 2) begin
                    chk("lit_b_s2", 32'(oFuSign), 32'd0);
                    chk("lit_b_x1s2", 32'(oFuData1), 32'h1180);
                    chk("lit_b_x2s2", 32'(oFuData2), 32'hF800);
                end
            end
        end else begin
            chk("ready", 32'(oReady), 32'(m_st == M_IDLE));
            chk("valid", 32'(oValid), 32'(m_st == M_DONE));
            chk("bypass", 32'(oFuBypass), 32'd1);
            chk("shift", 32'(oFuShift), 32'd0);
            chk("sign", 32'(oFuSign), 32'd0);
            if (m_st == M_DONE) begin
                chk("res_x", 32'(oX), 32'(sx[NSTEP]));
                chk("res_y", 32'(oY), 32'(sy[NSTEP]));
                chk("res_z", 32'(oZ), 32'(sz[NSTEP]));
                chk("d1_done", 32'(oFuData1), 32'(sx[NSTEP]));
                chk("d2_done", 32'(oFuData2), 32'(sy[NSTEP]));
            end else begin
                chk("d1_idle", 32'(oFuData1), 32'(lx));
                chk("d2_idle", 32'(oFuData2), 32'(ly));
            end
            if (m_clean) begin
                chk("rst_x", 32'(oX), 32'd0);
                chk("rst_y", 32'(oY), 32'd0);
                chk("rst_z", 32'(oZ), 32'd0);
            end
        end
    end

    task automatic job(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
        @(negedge iClk);
        iX = x; iY = y; iZ = z; iValid = 1'b1;
        @(negedge iClk);
        iValid = 1'b0;
        repeat (39) @(negedge iClk);
    endtask

    logic [DW-1:0] bx [3] = '{16'h1100, 16'h0F00, 16'h1300};
    logic [DW-1:0] by [3] = '{16'h0000, 16'h0080, 16'hFE00};
    logic [DW-1:0] bz [3] = '{16'h7FFF, 16'h0000, 16'hC000};

    initial begin
        repeat (2) @(negedge iClk);
        iRstN = 1'b1;
        job(16'h1000, 16'h0000, 16'h0800);
        job(16'h1200, 16'h0100, 16'hF800);
        job(16'h0C00, 16'h0400, 16'h8000);

        // Backpressure: second job waits behind a stalled result.
        @(negedge iClk);
        iReady = 1'b0;
        iX = 16'h0A00; iY = 16'h0200; iZ = 16'h1000; iValid = 1'b1;
        @(negedge iClk);
        iX = 16'h0800; iY = 16'hFF00; iZ = 16'hE000;
        repeat (46) @(negedge iClk);
        iReady = 1'b1;
        repeat (2) @(negedge iClk);
        iValid = 1'b0;
        repeat (40) @(negedge iClk);

        // Abort during step 7, then run a clean job.
        @(negedge iClk);
        iX = 16'h1000; iY = 16'h1000; iZ = 16'h2000; iValid = 1'b1;
        @(negedge iClk);
        iValid = 1'b0;
        repeat (12) @(negedge iClk);
        @(posedge iClk);
        #3 iRstN = 1'b0;
        repeat (2) @(negedge iClk);
        iRstN = 1'b1;
        job(16'h0900, 16'h0300, 16'h0400);

        // Back-to-back with iValid held high.
        iReady = 1'b1;
        @(negedge iClk);
        for (int j = 0; j < 3; j++) begin
            iX = bx[j]; iY = by[j]; iZ = bz[j]; iValid = 1'b1;
            repeat (38) @(negedge iClk);
        end
        iValid = 1'b0;
        repeat (5) @(negedge iClk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
